// File: rtl/div_pkg.sv
// Shared types and constants for the 16/8 sequential restoring divider.
package div_pkg;

    localparam int NW_DEF = 16;
    localparam int DW_DEF = 8;
    localparam int CW_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient reported when the divisor is zero: saturate to all ones.
    localparam logic [NW_DEF-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_16x8_seq_if.sv
// Request/result handshake bundle between a divider client and the divider.
interface div_16x8_seq_if
    import div_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract.
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] pr,
    input  logic          dvd_bit,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] pr_next,
    output logic          q_bit
);

    // The shifted remainder needs one extra bit so the compare never wraps.
    logic [DW:0] shifted;
    logic [DW:0] diff;

    assign shifted = {pr, dvd_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // After a successful subtract the result is below the divisor, so DW bits suffice.
    assign pr_next = q_bit ? diff[DW-1:0] : shifted[DW-1:0];

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider: one quotient bit per clock behind valid/ready handshakes.
module div_16x8_seq
    import div_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    div_16x8_seq_if.slave  bus
);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [NW-1:0] dvd_reg;
    logic [DW-1:0] dsr_reg;
    logic [DW-1:0] pr_reg;
    logic [NW-1:0] quotient_reg;
    logic [DW-1:0] remainder_reg;
    logic          dbz_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;

    logic [DW-1:0] pr_next;
    logic          q_bit;

    div_step #(.DW(DW)) u_step (
        .pr      (pr_reg),
        .dvd_bit (dvd_reg[NW-1]),
        .divisor (dsr_reg),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    // Quotient bits are shifted into the vacated LSBs of the dividend register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            pr_reg        <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        dvd_reg      <= bus.dividend;
                        dsr_reg      <= bus.divisor;
                        pr_reg       <= '0;
                        in_ready_reg <= 1'b0;
                        if (bus.divisor == '0) begin
                            quotient_reg  <= NW'(DBZ_QUOTIENT);
                            remainder_reg <= bus.dividend[DW-1:0];
                            dbz_reg       <= 1'b1;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            cnt_reg   <= CW'(NW);
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd_reg <= {dvd_reg[NW-2:0], q_bit};
                    pr_reg  <= pr_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        quotient_reg  <= {dvd_reg[NW-2:0], q_bit};
                        remainder_reg <= pr_next;
                        dbz_reg       <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: arithmetic reference model plus directed vectors.
module tb_div_16x8_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    div_16x8_seq_if bus ();

    div_16x8_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: results follow from plain integer division of the accepted operands.
    logic        have_exp;
    logic [15:0] exp_q, last_q;
    logic [7:0]  exp_r, last_r;
    logic        exp_z, last_z;

    initial begin
        have_exp = 1'b0;
        last_q = '0; last_r = '0; last_z = 1'b0;
        exp_q = '0; exp_r = '0; exp_z = 1'b0;
        wait (rst == 1'b0);
        forever begin
            @(negedge clk);
            check("ready_valid_exclusive", 32'(bus.in_ready & bus.out_valid), 32'd0);
            if (bus.out_valid) begin
                if (!have_exp) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check("model_quotient", 32'(bus.quotient), 32'(exp_q));
                    check("model_remainder", 32'(bus.remainder), 32'(exp_r));
                    check("model_dbz", 32'(bus.div_by_zero), 32'(exp_z));
                    last_q = exp_q; last_r = exp_r; last_z = exp_z;
                end
            end else begin
                check("hold_quotient", 32'(bus.quotient), 32'(last_q));
                check("hold_remainder", 32'(bus.remainder), 32'(last_r));
                check("hold_dbz", 32'(bus.div_by_zero), 32'(last_z));
            end
            if (rst) begin
                have_exp = 1'b0;
                last_q = '0; last_r = '0; last_z = 1'b0;
            end else if (bus.in_valid && bus.in_ready) begin
                if (bus.divisor == 8'd0) begin
                    exp_q = 16'hFFFF;
                    exp_r = bus.dividend[7:0];
                    exp_z = 1'b1;
                end else begin
                    exp_q = 16'(int'(bus.dividend) / int'(bus.divisor));
                    exp_r = 8'(int'(bus.dividend) % int'(bus.divisor));
                    exp_z = 1'b0;
                end
                have_exp = 1'b1;
            end
        end
    end

    // Issue one division, wait for its result, apply `hold` cycles of backpressure, then consume it.
    task automatic do_txn(input logic [15:0] a, input logic [7:0] b, input int hold,
                          output logic [15:0] q, output logic [7:0] r, output logic z,
                          output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = ~a;
            bus.divisor  = b + 8'd1;
            @(posedge clk); #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_quotient_stable", 32'(bus.quotient), 32'(q));
            check("bp_remainder_stable", 32'(bus.remainder), 32'(r));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        $display("txn %04h / %02h -> q=%04h r=%02h dbz=%0d lat=%0d hold=%0d", a, b, q, r, z, lat, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  op_a;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.dividend = '0;   bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_quotient", 32'(bus.quotient), 32'd0);
        check("reset_remainder", 32'(bus.remainder), 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);

        do_txn(16'hFFFF, 8'hFF, 0, q, r, z, lat);
        check("t1_quotient", 32'(q), 32'h0101);
        check("t1_remainder", 32'(r), 32'h00);
        check("t1_dbz", 32'(z), 32'd0);
        check("t1_latency", 32'(lat), 32'd16);

        do_txn(16'd1000, 8'd7, 0, q, r, z, lat);
        check("t2a_quotient", 32'(q), 32'd142);
        check("t2a_remainder", 32'(r), 32'd6);
        do_txn(16'h0001, 8'hFF, 1, q, r, z, lat);
        check("t2b_quotient", 32'(q), 32'd0);
        check("t2b_remainder", 32'(r), 32'd1);

        do_txn(16'h1234, 8'h00, 0, q, r, z, lat);
        check("t3_quotient", 32'(q), 32'hFFFF);
        check("t3_remainder", 32'(r), 32'h34);
        check("t3_dbz", 32'(z), 32'd1);
        check("t3_latency", 32'(lat), 32'd0);

        do_txn(16'd5000, 8'd9, 10, q, r, z, lat);
        check("t4_quotient", 32'(q), 32'd555);
        check("t4_remainder", 32'(r), 32'd5);

        // Abort mid-calculation: reset lands on the 7th step edge.
        bus.dividend = 16'hABCD; bus.divisor = 8'h13; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        do_txn(16'hABCD, 8'h13, 0, q, r, z, lat);
        check("t5_quotient", 32'(q), 32'h090A);
        check("t5_remainder", 32'(r), 32'h0F);

        do_txn(16'h0000, 8'h05, 0, q, r, z, lat);
        check("zero_dividend_quotient", 32'(q), 32'd0);
        check("zero_dividend_remainder", 32'(r), 32'd0);
        check("zero_dividend_latency", 32'(lat), 32'd16);
        do_txn(16'hBEEF, 8'h01, 0, q, r, z, lat);
        check("div1_quotient", 32'(q), 32'hBEEF);
        check("div1_remainder", 32'(r), 32'd0);

        // Every divisor, with the dividend formed as an exact 8x8 product.
        for (int bi = 0; bi < 256; bi++) begin
            b    = 8'(bi);
            op_a = 8'((bi * 73 + 29) & 255);
            a    = 16'(int'(op_a) * bi);
            do_txn(a, b, int'($urandom_range(0, 2)), q, r, z, lat);
            if (b != 8'd0) begin
                check("recover_operand", 32'(q), 32'(op_a));
                check("recover_remainder", 32'(r), 32'd0);
            end
        end

        for (int k = 0; k < 1500; k++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            do_txn(a, b, int'($urandom_range(0, 3)), q, r, z, lat);
            if (b != 8'd0) begin
                check("rand_identity", 32'(int'(q) * int'(b) + int'(r)), 32'(a));
                check("rand_rem_lt_div", 32'(r < b), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
